// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, one bit per cycle, with a valid/ready handshake.
module muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] srcA,
   input  logic [XLEN-1:0] srcB,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            z,
   output logic            n,
   output logic            busy
);

   localparam int CW = $clog2(XLEN);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   typedef enum logic [2:0] {
      OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
   } op_t;

   state_t              state;
   logic [CW-1:0]       step;
   op_t                 op_q;
   logic                neg_q;
   logic [XLEN-1:0]     opnd;
   logic [2*XLEN-1:0]   acc;

   op_t                 op_in;
   logic                neg_a, neg_b, b_zero, ovf, special;
   logic [XLEN-1:0]     mag_a, mag_b, special_res, calc_res;
   logic [XLEN:0]       sum, shifted, trial;
   logic [2*XLEN-1:0]   acc_mul, acc_div, acc_next, prod_s;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);

   // Operand conditioning at the accept edge.
   assign op_in  = op_t'(op);
   assign neg_a  = srcA[XLEN-1] & (op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
   assign neg_b  = srcB[XLEN-1] & (op_in inside {OP_MULH, OP_DIV, OP_REM});
   assign mag_a  = neg_a ? XLEN'(0) - srcA : srcA;
   assign mag_b  = neg_b ? XLEN'(0) - srcB : srcB;
   assign b_zero = op[2] && (srcB == '0);
   assign ovf    = (op_in inside {OP_DIV, OP_REM}) && &srcB
                   && (srcA == {1'b1, {(XLEN-1){1'b0}}});
   assign special     = b_zero || ovf;
   assign special_res = b_zero ? (op[1] ? srcA : '1) : (op[1] ? '0 : srcA);

   // One iteration: acc holds {partial, multiplier} or {remainder, quotient}.
   assign sum     = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
   assign acc_mul = {sum, acc[XLEN-1:1]};
   assign shifted = acc[2*XLEN-1:XLEN-1];
   assign trial   = shifted - {1'b0, opnd};
   assign acc_div = trial[XLEN] ? {shifted[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                : {trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
   assign acc_next = op_q[2] ? acc_div : acc_mul;
   assign prod_s   = neg_q ? (2*XLEN)'(0) - acc_next : acc_next;

   // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
   always_comb begin
      calc_res = '0;
      case (op_q)
         OP_MUL:                        calc_res = prod_s[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU:  calc_res = prod_s[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:               calc_res = neg_q ? XLEN'(0) - acc_next[XLEN-1:0]
                                                         : acc_next[XLEN-1:0];
         default:                       calc_res = neg_q ? XLEN'(0) - acc_next[2*XLEN-1:XLEN]
                                                         : acc_next[2*XLEN-1:XLEN];
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         step   <= '0;
         result <= '0;
         z      <= 1'b0;
         n      <= 1'b0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               step <= '0;
               if (special) begin
                  state  <= DONE;
                  result <= special_res;
                  z      <= (special_res == '0);
                  n      <= special_res[XLEN-1];
               end else begin
                  state <= CALC;
               end
            end
            CALC: if (flush) begin
               state <= IDLE;
            end else begin
               step <= step + 1'b1;
               if (step == CW'(XLEN-1)) begin
                  state  <= DONE;
                  result <= calc_res;
                  z      <= (calc_res == '0);
                  n      <= calc_res[XLEN-1];
               end
            end
            default: if (flush || out_ready) state <= IDLE;
         endcase
      end
   end

   // NOTE: datapath registers carry no reset; the control FSM guarantees they are loaded before use.
   always_ff @(posedge clk) begin
      if (state == IDLE && in_valid) begin
         op_q  <= op_in;
         neg_q <= op[2] ? (op[1] ? neg_a : neg_a ^ neg_b) : neg_a ^ neg_b;
         opnd  <= op[2] ? mag_b : mag_a;
         acc   <= {{XLEN{1'b0}}, op[2] ? mag_a : mag_b};
      end else if (state == CALC) begin
         acc <= acc_next;
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (XLEN=32): directed corner cases plus
// randomized operations checked against a plain-arithmetic reference model.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [2:0]  op = '0;
   logic [31:0] srcA = '0, srcB = '0;
   logic        flush = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] result;
   logic        z, n, busy;

   int n_checks = 0;
   int n_pass   = 0;

   muldiv_unit #(.XLEN(32)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .srcA(srcA), .srcB(srcB), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .result(result),
      .z(z), .n(n), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, required 0x%0h", tag, got, exp);
   endtask

   function automatic bit is_special(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      return (o[2] && b == 0) || ((o == 3'b100 || o == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
   endfunction

   // Reference model straight from the RV32M definitions using 64-bit arithmetic.
   function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      longint      sa = longint'($signed(a));
      longint      sb = longint'($signed(b));
      longint      ua = longint'({32'h0, a});
      longint      ub = longint'({32'h0, b});
      logic [63:0] p;
      if (o[2] && b == 0) return o[1] ? a : 32'hFFFF_FFFF;
      case (o)
         3'b000: p = ua * ub;
         3'b001: p = sa * sb;
         3'b010: p = sa * ub;
         3'b011: p = {32'h0, a} * {32'h0, b};
         3'b100: p = sa / sb;
         3'b101: p = ua / ub;
         3'b110: p = sa % sb;
         default: p = ua % ub;
      endcase
      return (o inside {3'b001, 3'b010, 3'b011}) ? p[63:32] : p[31:0];
   endfunction

   task automatic start_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      op = o; srcA = a; srcB = b; in_valid = 1'b1;
      check("in_ready_before_accept", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      op = 3'($urandom); srcA = $urandom; srcB = $urandom;
   endtask

   task automatic wait_done(input int limit, output int lat);
      lat = 1;
      while (!out_valid && lat < limit) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input int hold);
      int          lat;
      logic [31:0] exp;
      exp = model(o, a, b);
      start_op(o, a, b);
      wait_done(60, lat);
      check($sformatf("latency op%0d", o), lat, is_special(o, a, b) ? 1 : 33);
      if (out_valid) begin
         check($sformatf("result op%0d a=%h b=%h", o, a, b), result, exp);
         check("z_flag", z, exp == 0);
         check("n_flag", n, exp[31]);
         for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            op = 3'($urandom); srcA = $urandom; srcB = $urandom;
            @(posedge clk); #1;
            check("hold_out_valid", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
            check("hold_result", {result, z, n}, {exp, exp == 0, exp[31]});
         end
         in_valid = 1'b0;
         out_ready = 1'b1;
         @(posedge clk); #1;
         out_ready = 1'b0;
         check("consumed_out_valid", out_valid, 0);
         check("consumed_in_ready", in_ready, 1);
      end
   endtask

   task automatic watch_quiet(input string tag, input int cycles);
      int pulses = 0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk); #1;
         if (out_valid) pulses++;
      end
      check(tag, pulses, 0);
   endtask

   initial begin
      int lat;
      logic [2:0]  o;
      logic [31:0] a, b;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_result", {result, z, n}, 0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      check("rst_in_ready", in_ready, 1);

      // Directed vectors
      run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 0);
      run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      run_op(3'b100, 32'hFFFF_FFEC, 32'd3, 0);
      run_op(3'b110, 32'hFFFF_FFEC, 32'd3, 0);
      run_op(3'b101, 32'hFFFF_FFEC, 32'd3, 0);
      run_op(3'b100, 32'd5, 32'd0, 0);
      run_op(3'b111, 32'd5, 32'd0, 0);
      run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 5);
      check("spot_mulhsu", model(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFF);

      // Flush mid-CALC, then reset mid-CALC: no result may appear
      start_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      repeat (9) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check("flush_out_valid", out_valid, 0);
      check("flush_in_ready", in_ready, 1);
      watch_quiet("flush_no_pulse", 40);
      start_op(3'b100, 32'd1000, 32'd7);
      repeat (9) @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      check("reset_in_ready", in_ready, 1);
      check("reset_busy", busy, 0);
      watch_quiet("reset_no_pulse", 40);
      run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);

      // Flush in IDLE is ignored and a simultaneous request is accepted
      @(negedge clk);
      flush = 1'b1; in_valid = 1'b1;
      op = 3'b101; srcA = 32'd100; srcB = 32'd7;
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      check("flush_idle_accept", busy, 1);
      wait_done(60, lat);
      check("flush_idle_latency", lat, 33);
      check("flush_idle_result", result, 32'd14);
      // Flush in DONE discards the result
      #1 flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check("flush_done_out_valid", out_valid, 0);
      check("flush_done_in_ready", in_ready, 1);

      // Randomized operations
      for (int i = 0; i < 60; i++) begin
         o = 3'($urandom);
         case ($urandom_range(0, 7))
            0: begin a = $urandom; b = 0; end
            1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2: begin a = 32'($signed($urandom_range(0, 200)) - 100);
                     b = 32'($signed($urandom_range(1, 20)) - 10); end
            3: begin a = $urandom; b = $urandom_range(1, 15); end
            default: begin a = $urandom; b = $urandom; end
         endcase
         run_op(o, a, b, $urandom_range(0, 2));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter: XLEN, default 32, operand/result width (even, >=8).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  operation request.
REQ-005 in_ready  output  1  unit can accept a request.
REQ-006 op  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 srcA  input  XLEN  operand A / dividend.
REQ-008 srcB  input  XLEN  operand B / divisor.
REQ-009 flush  input  1  abort the in-flight operation.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 result  output  XLEN  operation result.
REQ-013 z  output  1  result == 0, valid while out_valid.
REQ-014 n  output  1  result[XLEN-1], valid while out_valid.
REQ-015 busy  output  1  high in CALC or DONE.

Function
REQ-016 States: IDLE, CALC, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-017 Accept on a rising edge with in_valid & in_ready; op, srcA, srcB registered at that edge; inputs ignored afterwards.
REQ-018 Normal ops: IDLE->CALC at accept; CALC holds exactly XLEN cycles (radix-2, one bit per cycle, step counter 0..XLEN-1); CALC->DONE after the last step; out_valid first high XLEN+1 cycles after the accept edge.
REQ-019 Multiply: 2*XLEN-bit product; MUL returns low XLEN bits; MULH/MULHSU/MULHU return high XLEN bits with signed*signed, signed*unsigned, unsigned*unsigned operands.
REQ-020 Divide: restoring division on magnitudes; quotient truncates toward zero; remainder takes the sign of the dividend; DIVU/REMU unsigned.
REQ-021 Divide-by-zero (srcB==0): IDLE->DONE directly; out_valid one cycle after accept; DIV/DIVU = all ones, REM/REMU = srcA.
REQ-022 Signed overflow (DIV/REM, srcA = 1 followed by XLEN-1 zeros, srcB = all ones): IDLE->DONE directly; DIV = srcA, REM = 0.
REQ-023 DONE holds result, z, n stable until out_valid & out_ready; then DONE->IDLE; next accept no earlier than the following edge.
REQ-024 flush in CALC or DONE: next state IDLE, out_valid low next cycle, result discarded; flush in IDLE has no effect; flush at the same edge as out_ready in DONE counts as consumption (same next state).
REQ-025 Request at an edge with flush high and state IDLE is accepted normally.
REQ-026 result, z and n are don't-care outside DONE; the bench checks them only while out_valid.

Reset
REQ-027 rst_n low at a rising edge: state IDLE, step counter 0, out_valid 0, busy 0, result 0, z 0, n 0; in_ready 1 from the first edge with rst_n high.
REQ-028 Reset during CALC or DONE aborts the operation with no out_valid pulse; reset has priority over flush and accept.

Verification (XLEN=32)
REQ-029 MUL srcA=7, srcB=0xFFFFFFFD -> result 0xFFFFFFEB, n=1, out_valid exactly 33 cycles after accept.
REQ-030 MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000, z=1; MULHSU same operands -> 0xFFFFFFFF.
REQ-031 DIV srcA=-20, srcB=3 -> 0xFFFFFFFA; REM same -> 0xFFFFFFFE; DIVU 0xFFFFFFEC/3 -> 0x5555554E.
REQ-032 DIV 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5, DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM same -> 0, z=1; each out_valid 1 cycle after accept.
REQ-033 out_ready held low 5 cycles in DONE -> result, z, n, out_valid stable; in_valid high meanwhile not accepted (in_ready 0).
REQ-034 flush 10 cycles into CALC, then rst_n low 10 cycles into a second CALC -> no out_valid pulse either time; in_ready 1 on the next cycle; a following MULHU 0xFFFFFFFF*0xFFFFFFFF still returns 0xFFFFFFFE.
